// File: rtl/seq_serial_byte_assembler.sv
// Serial frame assembler: collects DATA_W LSB-first bits plus a parity bit and
// presents the word on o_d with frame-complete (o_en_a) and parity-good (o_en_b) qualifiers.
module seq_serial_byte_assembler #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_bit_valid,
    input  logic              i_bit_in,
    output logic [DATA_W-1:0] o_d,
    output logic              o_en_a,
    output logic              o_en_b,
    output logic              o_timeout_err,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_frame_cnt
);

    localparam int BC_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             PAR_INIT = 1'(PARITY_ODD);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic [DATA_W-1:0] r_shreg;
    logic              r_par;
    logic [DATA_W-1:0] r_d;
    logic              r_en_a;
    logic              r_en_b;
    logic              r_timeout_err;
    logic              r_busy;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              w_in_frame;
    logic              w_gap_hit;

    // Accumulated parity folded with the received parity bit must be zero.
    function automatic logic f_par_ok(input logic acc, input logic pbit);
        return ((acc ^ pbit) == 1'b0);
    endfunction

    assign w_in_frame = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    // A bit arriving in the same cycle wins over the timeout.
    assign w_gap_hit  = (TIMEOUT > 0) && w_in_frame && !i_bit_valid && (r_gap == GAP_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_SHIFT;
                else         w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (w_gap_hit)                                  w_state_nxt = ST_IDLE;
                else if (i_bit_valid && (r_bit_cnt == BIT_LAST)) w_state_nxt = ST_PARITY;
                else                                            w_state_nxt = ST_SHIFT;
            end
            ST_PARITY: begin
                if (w_gap_hit)        w_state_nxt = ST_IDLE;
                else if (i_bit_valid) w_state_nxt = ST_OUT;
                else                  w_state_nxt = ST_PARITY;
            end
            ST_OUT:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt     <= '0;
            r_gap         <= '0;
            r_shreg       <= '0;
            r_par         <= 1'b0;
            r_d           <= '0;
            r_en_a        <= 1'b0;
            r_en_b        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_en_a        <= (w_state_nxt == ST_OUT);
            r_en_b        <= (w_state_nxt == ST_OUT) && f_par_ok(r_par, i_bit_in);
            r_timeout_err <= w_gap_hit;
            r_busy        <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_OUT) begin
                r_d         <= r_shreg;
                r_frame_cnt <= r_frame_cnt + CNT_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bit_cnt <= '0;
                        r_shreg   <= '0;
                        r_par     <= PAR_INIT;
                        r_gap     <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (i_bit_valid) begin
                        r_shreg   <= {i_bit_in, r_shreg[DATA_W-1:1]};
                        r_par     <= r_par ^ i_bit_in;
                        r_bit_cnt <= r_bit_cnt + BC_ONE;
                        r_gap     <= '0;
                    end else begin
                        r_gap     <= r_gap + GAP_ONE;
                    end
                end
                ST_PARITY: begin
                    if (i_bit_valid) r_gap <= '0;
                    else             r_gap <= r_gap + GAP_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_d           = r_d;
    assign o_en_a        = r_en_a;
    assign o_en_b        = r_en_b;
    assign o_timeout_err = r_timeout_err;
    assign o_busy        = r_busy;
    assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_seq_serial_byte_assembler.sv
// Scoreboard bench for seq_serial_byte_assembler: stimulus pushes expected
// events, a negedge monitor pops and compares whenever en_a or timeout_err fires.
module tb_seq_serial_byte_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic [7:0] d;
    logic       en_a, en_b, timeout_err, busy;
    logic [7:0] frame_cnt;

    typedef struct {
        bit       is_to;
        bit [7:0] d;
        bit       en_b;
        bit [7:0] cnt;
    } exp_t;

    exp_t     sb_q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    bit [7:0] m_cnt = 8'd0;
    bit [7:0] m_d = 8'd0;

    seq_serial_byte_assembler #(
        .DATA_W(8), .PARITY_ODD(0), .TIMEOUT(16), .CNT_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bit_valid(bit_valid),
        .i_bit_in(bit_in), .o_d(d), .o_en_a(en_a), .o_en_b(en_b),
        .o_timeout_err(timeout_err), .o_busy(busy), .o_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_b && !en_a) chk("en_b_without_en_a", 32'(en_b), 32'd0);
            if (en_a || timeout_err) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_event", 32'({en_a, timeout_err}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("evt_en_a", 32'(en_a), 32'(!e.is_to));
                    chk("evt_timeout_err", 32'(timeout_err), 32'(e.is_to));
                    chk("evt_d", 32'(d), 32'(e.d));
                    chk("evt_en_b", 32'(en_b), e.is_to ? 32'd0 : 32'(e.en_b));
                    chk("evt_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                    if (e.is_to) chk("busy_at_timeout", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Ends in the OUT cycle; caller ticks back to IDLE.
    task automatic frame(input bit [7:0] data, input bit pbit, input int gap, input bit mid_start);
        exp_t e;
        m_cnt   = m_cnt + 8'd1;
        m_d     = data;
        e.is_to = 1'b0;
        e.d     = data;
        e.en_b  = ((^data) ^ pbit) == 1'b0;
        e.cnt   = m_cnt;
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = mid_start && (i == 3) && (g == 0);
                tick();
            end
            start = 1'b0;
            send_bit(data[i]);
        end
        for (int g = 0; g < gap; g++) tick();
        send_bit(pbit);
    endtask

    initial begin
        exp_t e;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_en_a", 32'(en_a), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // 0xA5 good parity, then bad parity
        frame(8'hA5, 1'b0, 0, 1'b0);
        tick();
        chk("t1_busy_after", 32'(busy), 32'd0);
        frame(8'hA5, 1'b1, 0, 1'b0);
        tick();
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // timeout after 3 bits and 16 idle cycles
        e.is_to = 1'b1; e.d = m_d; e.en_b = 1'b0; e.cnt = m_cnt;
        sb_q.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        repeat (15) tick();
        chk("t3_busy_before_to", 32'(busy), 32'd1);
        tick();
        tick();
        chk("t3_d_kept", 32'(d), 32'hA5);

        // reset mid-frame after 5 data bits
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cnt = 8'd0;
        m_d   = 8'd0;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_d", 32'(d), 32'd0);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t4_pulses", 32'({en_a, en_b, timeout_err}), 32'd0);
        frame(8'h3C, 1'b0, 0, 1'b0);
        tick();

        // 15-cycle gaps never time out; mid-frame start ignored
        frame(8'h81, 1'b0, 15, 1'b1);
        tick();
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd2);

        // 256 frames wrap the counter; start in OUT is lost
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cnt = 8'd0;
        for (int f = 0; f < 256; f++) begin
            bit [7:0] v;
            v = 8'(f * 37 + 11);
            frame(v, ^v, 0, 1'b0);
            if (f == 255) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("t6_busy_after_out_start", 32'(busy), 32'd0);
        chk("t6_frame_cnt_wrap", 32'(frame_cnt), 32'd0);
        tick();
        chk("t6_busy_stays_idle", 32'(busy), 32'd0);

        repeat (3) tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
